// File: rtl/cfg_readback.sv
// cfg_readback: samples the configuration word on request and streams it
// MSB-first over a valid/ready bit interface, followed by an even-parity bit.
// Optional build macro CFG_READBACK_VOTE_EN adds two redundant cfg copies,
// a bitwise majority vote at capture and a registered disagreement flag.
module cfg_readback #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic [WIDTH-1:0] cfg,
`ifdef CFG_READBACK_VOTE_EN
  input  logic [WIDTH-1:0] cfg_b,
  input  logic [WIDTH-1:0] cfg_c,
  output logic             vote_err,
`endif
  input  logic             req,
  output logic             busy,
  output logic             sdo,
  output logic             sdo_valid,
  input  logic             sdo_ready,
  output logic             sdo_last,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] cap_word;
  logic [CW-1:0]    cnt;
  logic             par;

  // Word loaded into the shadow register at capture
`ifdef CFG_READBACK_VOTE_EN
  always_comb begin
    cap_word = (cfg & cfg_b) | (cfg & cfg_c) | (cfg_b & cfg_c);
  end
`else
  always_comb begin
    cap_word = cfg;
  end
`endif

  // State register
  always_ff @(posedge clkin) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and registered-state output decode
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    sdo       = 1'b0;
    sdo_valid = 1'b0;
    sdo_last  = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        sdo_valid = 1'b1;
        sdo       = shadow[cnt];
        if (sdo_ready && (cnt == '0)) state_nxt = PAR;
      end
      PAR: begin
        busy      = 1'b1;
        sdo_valid = 1'b1;
        sdo       = par;
        sdo_last  = 1'b1;
        if (sdo_ready) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture on accepted request; step the bit index on each shifted bit
  always_ff @(posedge clkin) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
      par    <= 1'b0;
    end else if ((state == IDLE) && req) begin
      shadow <= cap_word;
      par    <= ^cap_word;
      cnt    <= CW'(WIDTH - 1);
    end else if ((state == SHIFT) && sdo_ready && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

`ifdef CFG_READBACK_VOTE_EN
  // Disagreement flag, refreshed at every capture
  always_ff @(posedge clkin) begin
    if (rst) begin
      vote_err <= 1'b0;
    end else if ((state == IDLE) && req) begin
      vote_err <= |((cfg ^ cfg_b) | (cfg ^ cfg_c));
    end
  end
`endif

endmodule

// File: tb/tb_cfg_readback.sv
// tb_cfg_readback: table-driven cycle vectors plus hand-written sequences
// for random backpressure, latency and (when built with
// CFG_READBACK_VOTE_EN) the majority-vote path.
module tb_cfg_readback;

  localparam int unsigned W = 8;

  // expected output packing: {busy, sdo, sdo_valid, sdo_last, done}
  localparam logic [4:0] ID = 5'b00000;
  localparam logic [4:0] S0 = 5'b10100;
  localparam logic [4:0] S1 = 5'b11100;
  localparam logic [4:0] P0 = 5'b10110;
  localparam logic [4:0] P1 = 5'b11110;
  localparam logic [4:0] DN = 5'b10001;

  typedef struct {
    string      name;
    logic       rst;
    logic       req;
    logic       rdy;
    logic [7:0] cfg;
    logic [4:0] exp;
  } vec_t;

  logic         clkin;
  logic         rst;
  logic [W-1:0] cfg;
  logic         req;
  logic         busy;
  logic         sdo;
  logic         sdo_valid;
  logic         sdo_ready;
  logic         sdo_last;
  logic         done;
`ifdef CFG_READBACK_VOTE_EN
  logic [W-1:0] cfg_b;
  logic [W-1:0] cfg_c;
  logic         vote_err;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  vec_t        tbl[$];

  cfg_readback #(.WIDTH(W)) dut (
    .clkin     (clkin),
    .rst       (rst),
    .cfg       (cfg),
`ifdef CFG_READBACK_VOTE_EN
    .cfg_b     (cfg_b),
    .cfg_c     (cfg_c),
    .vote_err  (vote_err),
`endif
    .req       (req),
    .busy      (busy),
    .sdo       (sdo),
    .sdo_valid (sdo_valid),
    .sdo_ready (sdo_ready),
    .sdo_last  (sdo_last),
    .done      (done)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic r, input logic q, input logic y,
                     input logic [7:0] c, input logic [4:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.req = q; v.rdy = y; v.cfg = c; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive_cfg(input logic [W-1:0] c);
    cfg = c;
`ifdef CFG_READBACK_VOTE_EN
    cfg_b = c;
    cfg_c = c;
`endif
  endtask

  task automatic run_random(input int unsigned frames);
    logic [W-1:0] c;
    logic [W-1:0] got;
    logic         gotpar;
    int unsigned  nbits;
    int unsigned  cyc;
    bit           fin;
    for (int unsigned f = 0; f < frames; f++) begin
      c = W'($urandom);
      drive_cfg(c);
      req = 1'b1;
      sdo_ready = 1'($urandom_range(0, 1));
      tick();
      req = 1'b0;
      got = '0; gotpar = 1'b0; nbits = 0; fin = 1'b0; cyc = 0;
      while (!fin && cyc < 200) begin
        sdo_ready = 1'($urandom_range(0, 1));
        drive_cfg(W'($urandom));
        if (sdo_valid && sdo_ready) begin
          if (sdo_last) begin
            gotpar = sdo;
            fin = 1'b1;
          end else begin
            got = {got[W-2:0], sdo};
            nbits++;
          end
        end
        tick();
        cyc++;
      end
      check($sformatf("rand%0d_finished", f), 64'(fin), 64'd1);
      check($sformatf("rand%0d_done", f), 64'(done), 64'd1);
      check($sformatf("rand%0d_word", f), 64'(got), 64'(c));
      check($sformatf("rand%0d_parity", f), 64'(gotpar), 64'(^c));
      check($sformatf("rand%0d_nbits", f), 64'(nbits), 64'(W));
      tick();
      check($sformatf("rand%0d_idle", f), 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int unsigned  n;
    logic [W-1:0] got;
    rst = 1'b1; req = 1'b0; sdo_ready = 1'b0;
    drive_cfg('0);

    // reset dominates a simultaneous request
    add("rst0", 1, 1, 1, 8'hA5, ID);
    add("rst1", 1, 1, 1, 8'hA5, ID);
    // basic frame: A5 -> 1,0,1,0,0,1,0,1 then parity 0
    add("A0", 0, 1, 1, 8'hA5, S1);  add("A1", 0, 0, 1, 8'hA5, S0);
    add("A2", 0, 0, 1, 8'hA5, S1);  add("A3", 0, 0, 1, 8'hA5, S0);
    add("A4", 0, 0, 1, 8'hA5, S0);  add("A5", 0, 0, 1, 8'hA5, S1);
    add("A6", 0, 0, 1, 8'hA5, S0);  add("A7", 0, 0, 1, 8'hA5, S1);
    add("A8", 0, 0, 1, 8'hA5, P0);  add("A9", 0, 0, 1, 8'hA5, DN);
    add("A10", 0, 0, 1, 8'hA5, ID);
    // backpressure: 01 with ready 0/1, cfg forced to FF mid-frame
    add("B0", 0, 1, 1, 8'h01, S0);  add("B1", 0, 0, 0, 8'h01, S0);
    add("B2", 0, 0, 1, 8'h01, S0);  add("B3", 0, 0, 0, 8'h01, S0);
    add("B4", 0, 0, 1, 8'hFF, S0);  add("B5", 0, 0, 0, 8'hFF, S0);
    add("B6", 0, 0, 1, 8'hFF, S0);  add("B7", 0, 0, 0, 8'hFF, S0);
    add("B8", 0, 0, 1, 8'hFF, S0);  add("B9", 0, 0, 0, 8'hFF, S0);
    add("B10", 0, 0, 1, 8'hFF, S0); add("B11", 0, 0, 0, 8'hFF, S0);
    add("B12", 0, 0, 1, 8'hFF, S0); add("B13", 0, 0, 0, 8'hFF, S0);
    add("B14", 0, 0, 1, 8'hFF, S1); add("B15", 0, 0, 0, 8'hFF, S1);
    add("B16", 0, 0, 1, 8'hFF, P1); add("B17", 0, 0, 0, 8'hFF, P1);
    add("B18", 0, 0, 1, 8'hFF, DN); add("B19", 0, 0, 0, 8'hFF, ID);
    // request while busy / during DONE ignored; next one starts fresh
    add("C0", 0, 1, 1, 8'h5A, S0);  add("C1", 0, 0, 1, 8'h5A, S1);
    add("C2", 0, 0, 1, 8'h5A, S0);  add("C3", 0, 1, 1, 8'h5A, S1);
    add("C4", 0, 0, 1, 8'h5A, S1);  add("C5", 0, 0, 1, 8'h5A, S0);
    add("C6", 0, 0, 1, 8'h5A, S1);  add("C7", 0, 0, 1, 8'h5A, S0);
    add("C8", 0, 0, 1, 8'h5A, P0);  add("C9", 0, 0, 1, 8'h5A, DN);
    add("C10", 0, 1, 1, 8'h80, ID); add("C11", 0, 1, 1, 8'h80, S1);
    add("C12", 0, 0, 1, 8'h80, S0); add("C13", 0, 0, 1, 8'h80, S0);
    add("C14", 0, 0, 1, 8'h80, S0); add("C15", 0, 0, 1, 8'h80, S0);
    add("C16", 0, 0, 1, 8'h80, S0); add("C17", 0, 0, 1, 8'h80, S0);
    add("C18", 0, 0, 1, 8'h80, S0); add("C19", 0, 0, 1, 8'h80, P1);
    add("C20", 0, 0, 1, 8'h80, DN); add("C21", 0, 0, 1, 8'h80, ID);
    // reset mid-frame, then a full 3C frame
    add("D0", 0, 1, 1, 8'hA5, S1);  add("D1", 0, 0, 1, 8'hA5, S0);
    add("D2", 0, 0, 1, 8'hA5, S1);  add("D3", 0, 0, 1, 8'hA5, S0);
    add("D4", 0, 0, 1, 8'hA5, S0);  add("D5", 1, 0, 1, 8'hA5, ID);
    add("D6", 0, 0, 1, 8'hA5, ID);  add("D7", 0, 1, 1, 8'h3C, S0);
    add("D8", 0, 0, 1, 8'h3C, S0);  add("D9", 0, 0, 1, 8'h3C, S1);
    add("D10", 0, 0, 1, 8'h3C, S1); add("D11", 0, 0, 1, 8'h3C, S1);
    add("D12", 0, 0, 1, 8'h3C, S1); add("D13", 0, 0, 1, 8'h3C, S0);
    add("D14", 0, 0, 1, 8'h3C, S0); add("D15", 0, 0, 1, 8'h3C, P0);
    add("D16", 0, 0, 1, 8'h3C, DN); add("D17", 0, 0, 1, 8'h3C, ID);

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      sdo_ready = tbl[i].rdy;
      drive_cfg(tbl[i].cfg);
      tick();
      check(tbl[i].name, 64'({busy, sdo, sdo_valid, sdo_last, done}), 64'(tbl[i].exp));
    end
    rst = 1'b0; req = 1'b0;

    run_random(6);

    // latency with ready tied high
    sdo_ready = 1'b1;
    drive_cfg(8'hC3);
    req = 1'b1;
    tick();
    req = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(W + 2));

`ifdef CFG_READBACK_VOTE_EN
    cfg = 8'h3C; cfg_b = 8'h3C; cfg_c = 8'hFF;
    sdo_ready = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("vote_err_set", 64'(vote_err), 64'd1);
    got = '0;
    for (int unsigned k = 0; k < W; k++) begin
      got = {got[W-2:0], sdo};
      tick();
    end
    check("vote_word", 64'(got), 64'h3C);
    check("vote_par", 64'({sdo, sdo_last}), 64'b01);
    tick();
    tick();
    check("vote_err_hold", 64'(vote_err), 64'd1);
    drive_cfg(8'h3C);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("vote_err_clear", 64'(vote_err), 64'd0);
    for (int unsigned k = 0; k < W + 2; k++) tick();
    check("vote_idle", 64'(busy), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
